bus_register_file: RTL and testbench
====================================

# bus_register_file

Parametrised register file for the CPU's shared-bus datapath: general-purpose registers, a status register (SR) and a bounded stack pointer (SP), all loaded from the data bus under one-hot `rin` and read onto the bus under one-hot `rout`. Per-register tri-state buffers are replaced by a priority read mux with multi-driver detection. The block adds stack overflow/underflow protection and a debug read port for the seven-segment driver. It sits between the control unit and the bus.

## Interface
- `DATA_W`, 16, register and bus width
- `NUM_GPR`, 14, number of general-purpose registers; SR index = `NUM_GPR`, SP index = `NUM_GPR+1`, `NREG = NUM_GPR+2`
- `SR_W`, 4, ALU status flag width (≤ `DATA_W`)
- `STACK_HI`, 16'hFFFF, highest legal SP value; SP reset value
- `STACK_LO`, 16'hFF00, lowest legal SP value (`STACK_LO < STACK_HI`)

- `clk` in 1: clock; all state on rising edge
- `rst` in 1: reset; synchronous, active-low
- `bus_in` in `DATA_W`: current bus value
- `rin` in `NREG`: one-hot write enables
- `rout` in `NREG`: one-hot read enables
- `sp_sel` in 2: SP operation when `rin[SP]` is set: 00 load, 01 push (decrement), 10 pop (increment), 11 hold
- `sr_sel` in 1: SR source; 0 = `bus_in`, 1 = zero-extended `alu_status`
- `alu_status` in `SR_W`: ALU flags
- `err_clr` in 1: clears all sticky error flags
- `dbg_sel` in `$clog2(NREG)`: debug read index
- `bus_out` out `DATA_W`: selected register value, combinational
- `bus_drive` out 1: `|rout`
- `sp_out` out `DATA_W`: current SP (RAM address mux)
- `sr_out` out `SR_W`: `SR[SR_W-1:0]` (control unit condition codes)
- `dbg_data` out `DATA_W`: register `dbg_sel`; 0 if out of range
- `err_conflict`, `err_ovf`, `err_udf` out 1: sticky error flags

## Operation
- Reset (`rst`=0 at edge): all GPRs and SR = 0; SP = `STACK_HI`; all error flags = 0. Reset overrides every other input in the same cycle.
- GPR write: `rin[i]` → `R[i] <= bus_in`.
- SR write: `rin[SR]` → SR <= `sr_sel ? {0, alu_status} : bus_in`.
- SP write when `rin[SP]`:
  - load: SP <= `bus_in` clamped to [`STACK_LO`, `STACK_HI`]; clamping below sets `err_udf`… no: clamping below sets `err_ovf`, clamping above sets `err_udf`.
  - push: if SP == `STACK_LO`, hold and set `err_ovf`; else SP-1.
  - pop: if SP == `STACK_HI`, hold and set `err_udf`; else SP+1.
  - hold: no change.
- Multiple `rin` bits set: every selected register is written (broadcast is legal).
- Read: `bus_out` = register at the lowest set index of `rout`; all-zero `rout` gives 0.
- Conflict: more than one bit of `rout` set → `err_conflict` is set at the next edge; `bus_out` keeps the priority value.
- `err_clr` clears the flags at the edge. An error event in the same cycle wins, and its flag stays set.

## Timing
- Reads are combinational. Writes take effect at the next rising edge; the written value is visible on `bus_out`/`dbg_data` in the following cycle.
- Same-cycle read and write of one register: `bus_out` shows the old value.
- `sp_out`, `sr_out` and error flags are registered values with one-cycle latency from their causing edge.
- Reset asserted mid push/pop sequence: SP returns to `STACK_HI` at that edge and no flag is set.

## Structure
- Shared package `cpu_pkg`: `sp_sel` encodings (`SP_LOAD`, `SP_PUSH`, `SP_POP`, `SP_HOLD`), SR bit positions, and `SR_IDX`/`SP_IDX` derivation functions.
- Sub-module `stack_pointer_bounded`: SP register, bounds checks, clamping, `ovf`/`udf` pulses. Sticky flags live in the top.
- GPRs are generated with a `for` loop; the read mux is a priority encoder plus index select.

## Test plan
- Reset then `rin[3]`, `bus_in`=16'hA5A5; next cycle `rout[3]` → `bus_out`=16'hA5A5, `bus_drive`=1; `rout`=0 → `bus_out`=0.
- SP = 16'hFF01; push ×2 → SP 16'hFF00, then hold with `err_ovf`=1; `err_clr` → 0.
- After reset, pop → SP stays 16'hFFFF, `err_udf`=1. Load 16'h0010 → SP=16'hFF00, `err_ovf`=1.
- `rout` bits 2 and 5 set (R2=1, R5=2) → `bus_out`=1, `err_conflict`=1 next cycle. `err_clr` together with a conflict → flag remains 1.
- `sr_sel`=1, `alu_status`=4'b1010, `rin[SR]` → `sr_out`=4'b1010, `rout[SR]` gives 16'h000A. Same-cycle write/read of R1 shows the old value.
- Push three times, then `rst`=0 for one cycle → SP=16'hFFFF, all registers 0, all flags 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: stack-pointer operation codes, status
// register bit positions and the index helpers that place SR and SP after
// the general-purpose registers in the one-hot select vectors.
package cpu_pkg;

    // Stack-pointer operation selected by sp_sel when the SP is enabled
    localparam logic [1:0] SP_LOAD = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;
    localparam logic [1:0] SP_HOLD = 2'b11;

    // ALU status flag positions inside SR
    localparam int SR_BIT_C = 0;
    localparam int SR_BIT_Z = 1;
    localparam int SR_BIT_N = 2;
    localparam int SR_BIT_V = 3;

    // SR sits directly after the last GPR
    function automatic int sr_idx(input int num_gpr);
        return num_gpr;
    endfunction

    // SP sits directly after SR
    function automatic int sp_idx(input int num_gpr);
        return num_gpr + 1;
    endfunction

endpackage

// File: rtl/stack_pointer_bounded.sv
// Bounded stack pointer: holds SP, clamps loads into [STACK_LO, STACK_HI],
// refuses push at the low bound and pop at the high bound, and reports each
// refusal/clamp as a single-cycle ovf/udf pulse. Sticky flags live upstream.
module stack_pointer_bounded
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] STACK_HI = 16'hFFFF,
    parameter logic [DATA_W-1:0] STACK_LO = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] sp,
    output logic              ovf,
    output logic              udf
);

    logic [DATA_W-1:0] sp_r;
    logic [DATA_W-1:0] sp_next_s;
    logic              ovf_s;
    logic              udf_s;

    // Next SP value and bound-violation pulses for the selected operation
    always_comb begin
        sp_next_s = sp_r;
        ovf_s     = 1'b0;
        udf_s     = 1'b0;
        if (en) begin
            case (sel)
                SP_LOAD: begin
                    if (load_val < STACK_LO) begin
                        sp_next_s = STACK_LO;
                        ovf_s     = 1'b1;
                    end else if (load_val > STACK_HI) begin
                        sp_next_s = STACK_HI;
                        udf_s     = 1'b1;
                    end else begin
                        sp_next_s = load_val;
                    end
                end
                SP_PUSH: begin
                    if (sp_r == STACK_LO) begin
                        ovf_s = 1'b1;
                    end else begin
                        sp_next_s = sp_r - DATA_W'(1);
                    end
                end
                SP_POP: begin
                    if (sp_r == STACK_HI) begin
                        udf_s = 1'b1;
                    end else begin
                        sp_next_s = sp_r + DATA_W'(1);
                    end
                end
                default: begin
                    sp_next_s = sp_r;
                end
            endcase
        end else begin
            sp_next_s = sp_r;
        end
    end

    // SP register; reset parks it at the top of the stack
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_r <= STACK_HI;
        end else begin
            sp_r <= sp_next_s;
        end
    end

    assign sp  = sp_r;
    assign ovf = ovf_s;
    assign udf = udf_s;

endmodule

// File: rtl/bus_register_file.sv
// Shared-bus register file: GPRs, status register and bounded stack pointer
// loaded from the bus under one-hot rin and read back through a priority
// mux under rout. Multiple active read enables are flagged instead of
// fighting on the bus; stack bound violations raise sticky error flags.
module bus_register_file
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NUM_GPR  = 14,
    parameter int                SR_W     = 4,
    parameter logic [DATA_W-1:0] STACK_HI = 16'hFFFF,
    parameter logic [DATA_W-1:0] STACK_LO = 16'hFF00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                bus_in,
    input  logic [NUM_GPR+1:0]               rin,
    input  logic [NUM_GPR+1:0]               rout,
    input  logic [1:0]                       sp_sel,
    input  logic                             sr_sel,
    input  logic [SR_W-1:0]                  alu_status,
    input  logic                             err_clr,
    input  logic [$clog2(NUM_GPR+2)-1:0]     dbg_sel,
    output logic [DATA_W-1:0]                bus_out,
    output logic                             bus_drive,
    output logic [DATA_W-1:0]                sp_out,
    output logic [SR_W-1:0]                  sr_out,
    output logic [DATA_W-1:0]                dbg_data,
    output logic                             err_conflict,
    output logic                             err_ovf,
    output logic                             err_udf
);

    localparam int NREG  = NUM_GPR + 2;
    localparam int IDX_W = $clog2(NREG);
    localparam int SR_I  = sr_idx(NUM_GPR);
    localparam int SP_I  = sp_idx(NUM_GPR);

    logic [DATA_W-1:0] gpr_r [NUM_GPR];
    logic [DATA_W-1:0] sr_r;
    logic [DATA_W-1:0] sp_s;
    logic              sp_ovf_s;
    logic              sp_udf_s;
    logic [DATA_W-1:0] view_s [NREG];
    logic [IDX_W-1:0]  rd_idx_s;
    logic              rd_hit_s;
    logic              conflict_s;
    logic              err_conflict_r;
    logic              err_ovf_r;
    logic              err_udf_r;

    // General-purpose registers; broadcast writes to several GPRs are legal
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_GPR; i++) begin
            if (!rst) begin
                gpr_r[i] <= {DATA_W{1'b0}};
            end else if (rin[i]) begin
                gpr_r[i] <= bus_in;
            end else begin
                gpr_r[i] <= gpr_r[i];
            end
        end
    end

    // Status register, loaded from the bus or from the zero-extended ALU flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_r <= {DATA_W{1'b0}};
        end else if (rin[SR_I]) begin
            sr_r <= sr_sel ? DATA_W'(alu_status) : bus_in;
        end else begin
            sr_r <= sr_r;
        end
    end

    stack_pointer_bounded #(
        .DATA_W   (DATA_W),
        .STACK_HI (STACK_HI),
        .STACK_LO (STACK_LO)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .en       (rin[SP_I]),
        .sel      (sp_sel),
        .load_val (bus_in),
        .sp       (sp_s),
        .ovf      (sp_ovf_s),
        .udf      (sp_udf_s)
    );

    // Flatten all registers into one indexable view for bus and debug reads
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            view_s[i] = gpr_r[i];
        end
        view_s[SR_I] = sr_r;
        view_s[SP_I] = sp_s;
    end

    // Priority encoder: scanning downwards leaves the lowest set rout index
    always_comb begin
        rd_idx_s = {IDX_W{1'b0}};
        rd_hit_s = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            rd_idx_s = rout[i] ? i[IDX_W-1:0] : rd_idx_s;
            rd_hit_s = rd_hit_s | rout[i];
        end
    end

    // Bus read value; an idle rout drives zero rather than a stale register
    always_comb begin
        if (rd_hit_s) begin
            bus_out = view_s[rd_idx_s];
        end else begin
            bus_out = {DATA_W{1'b0}};
        end
    end

    // Debug port for the display driver; indices past the last register read zero
    always_comb begin
        if (int'(dbg_sel) < NREG) begin
            dbg_data = view_s[dbg_sel];
        end else begin
            dbg_data = {DATA_W{1'b0}};
        end
    end

    // More than one read enable: clearing the lowest set bit leaves something
    assign conflict_s = |(rout & (rout - (NUM_GPR + 2)'(1)));
    assign bus_drive  = |rout;

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_conflict_r <= 1'b0;
            err_ovf_r      <= 1'b0;
            err_udf_r      <= 1'b0;
        end else begin
            err_conflict_r <= conflict_s | (err_conflict_r & ~err_clr);
            err_ovf_r      <= sp_ovf_s   | (err_ovf_r      & ~err_clr);
            err_udf_r      <= sp_udf_s   | (err_udf_r      & ~err_clr);
        end
    end

    assign sp_out       = sp_s;
    assign sr_out       = sr_r[SR_W-1:0];
    assign err_conflict = err_conflict_r;
    assign err_ovf      = err_ovf_r;
    assign err_udf      = err_udf_r;

endmodule

// File: tb/tb_bus_register_file.sv
// Self-checking bench for bus_register_file: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_bus_register_file;

    localparam logic [15:0] HI = 16'hFFFF;
    localparam logic [15:0] LO = 16'hFF00;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [1:0]  sp_sel;
    logic        sr_sel;
    logic [3:0]  alu_status;
    logic        err_clr;
    logic [3:0]  dbg_sel;
    logic [15:0] bus_out;
    logic        bus_drive;
    logic [15:0] sp_out;
    logic [3:0]  sr_out;
    logic [15:0] dbg_data;
    logic        err_conflict;
    logic        err_ovf;
    logic        err_udf;

    // Reference state: index 0..13 GPRs, 14 SR, 15 SP
    logic [15:0] m_reg [16];
    logic        m_conf;
    logic        m_ovf;
    logic        m_udf;

    int n_cmp = 0;
    int n_err = 0;

    bus_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .bus_in       (bus_in),
        .rin          (rin),
        .rout         (rout),
        .sp_sel       (sp_sel),
        .sr_sel       (sr_sel),
        .alu_status   (alu_status),
        .err_clr      (err_clr),
        .dbg_sel      (dbg_sel),
        .bus_out      (bus_out),
        .bus_drive    (bus_drive),
        .sp_out       (sp_out),
        .sr_out       (sr_out),
        .dbg_data     (dbg_data),
        .err_conflict (err_conflict),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_bus();
        for (int i = 0; i < 16; i++) begin
            if (rout[i]) return m_reg[i];
        end
        return 16'h0000;
    endfunction

    // Advance the reference model by one clock using the current inputs
    task automatic model_step();
        logic ovf_e;
        logic udf_e;
        logic conf_e;
        ovf_e = 1'b0;
        udf_e = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 15; i++) m_reg[i] = 16'h0000;
            m_reg[15] = HI;
            m_conf = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (rin[i]) m_reg[i] = bus_in;
            end
            if (rin[14]) m_reg[14] = sr_sel ? {12'h000, alu_status} : bus_in;
            if (rin[15]) begin
                if (sp_sel == 2'd0) begin
                    if (bus_in < LO) begin m_reg[15] = LO; ovf_e = 1'b1; end
                    else if (bus_in > HI) begin m_reg[15] = HI; udf_e = 1'b1; end
                    else m_reg[15] = bus_in;
                end else if (sp_sel == 2'd1) begin
                    if (m_reg[15] == LO) ovf_e = 1'b1;
                    else m_reg[15] = m_reg[15] - 16'd1;
                end else if (sp_sel == 2'd2) begin
                    if (m_reg[15] == HI) udf_e = 1'b1;
                    else m_reg[15] = m_reg[15] + 16'd1;
                end
            end
            conf_e = ($countones(rout) > 1);
            m_conf = conf_e | (m_conf & !err_clr);
            m_ovf  = ovf_e  | (m_ovf  & !err_clr);
            m_udf  = udf_e  | (m_udf  & !err_clr);
        end
    endtask

    // Check combinational reads, clock once, then check registered outputs
    task automatic cycle();
        #1;
        check("bus_out", bus_out, exp_bus());
        check("bus_drive", {15'h0, bus_drive}, {15'h0, (|rout)});
        check("dbg_data", dbg_data, m_reg[dbg_sel]);
        model_step();
        @(posedge clk);
        #1;
        check("sp_out", sp_out, m_reg[15]);
        check("sr_out", {12'h0, sr_out}, {12'h0, m_reg[14][3:0]});
        check("err_conflict", {15'h0, err_conflict}, {15'h0, m_conf});
        check("err_ovf", {15'h0, err_ovf}, {15'h0, m_ovf});
        check("err_udf", {15'h0, err_udf}, {15'h0, m_udf});
    endtask

    task automatic idle();
        rst        = 1'b1;
        bus_in     = 16'h0000;
        rin        = 16'h0000;
        rout       = 16'h0000;
        sp_sel     = 2'b11;
        sr_sel     = 1'b0;
        alu_status = 4'h0;
        err_clr    = 1'b0;
        dbg_sel    = 4'h0;
    endtask

    initial begin
        logic [15:0] pick;
        for (int i = 0; i < 16; i++) m_reg[i] = 16'hxxxx;
        m_conf = 1'bx;
        m_ovf  = 1'bx;
        m_udf  = 1'bx;

        // Reset
        idle(); rst = 1'b0; dbg_sel = 4'd15;
        model_step(); @(posedge clk); #1;
        check("rst_sp", sp_out, 16'hFFFF);
        check("rst_flags", {13'h0, err_conflict, err_ovf, err_udf}, 16'h0000);

        // Write R3, read it back, then idle bus
        idle(); rin[3] = 1'b1; bus_in = 16'hA5A5; cycle();
        idle(); rout[3] = 1'b1; #1; check("r3_read", bus_out, 16'hA5A5); cycle();
        idle(); cycle();
        check("idle_bus", bus_out, 16'h0000);

        // Push into the low bound
        idle(); rin[15] = 1'b1; sp_sel = 2'b00; bus_in = 16'hFF01; cycle();
        idle(); rin[15] = 1'b1; sp_sel = 2'b01; cycle();
        check("push1", sp_out, 16'hFF00);
        idle(); rin[15] = 1'b1; sp_sel = 2'b01; cycle();
        check("push_ovf", {15'h0, err_ovf}, 16'h0001);
        check("push_hold", sp_out, 16'hFF00);
        idle(); err_clr = 1'b1; cycle();
        check("ovf_clr", {15'h0, err_ovf}, 16'h0000);

        // Pop from the top after reset; clamp a low load
        idle(); rst = 1'b0; cycle();
        idle(); rin[15] = 1'b1; sp_sel = 2'b10; cycle();
        check("pop_udf", {15'h0, err_udf}, 16'h0001);
        idle(); rin[15] = 1'b1; sp_sel = 2'b00; bus_in = 16'h0010; cycle();
        check("load_clamp", sp_out, 16'hFF00);

        // Conflict with priority read; clear loses against a new conflict
        idle(); rin[2] = 1'b1; bus_in = 16'h0001; cycle();
        idle(); rin[5] = 1'b1; bus_in = 16'h0002; cycle();
        idle(); rout[2] = 1'b1; rout[5] = 1'b1; #1; check("prio_read", bus_out, 16'h0001); cycle();
        check("conflict", {15'h0, err_conflict}, 16'h0001);
        idle(); rout[2] = 1'b1; rout[5] = 1'b1; err_clr = 1'b1; cycle();
        check("conflict_win", {15'h0, err_conflict}, 16'h0001);

        // SR from ALU flags; same-cycle write/read of R1
        idle(); rin[14] = 1'b1; sr_sel = 1'b1; alu_status = 4'b1010; cycle();
        check("sr_alu", {12'h0, sr_out}, 16'h000A);
        idle(); rout[14] = 1'b1; #1; check("sr_read", bus_out, 16'h000A); cycle();
        idle(); rin[1] = 1'b1; bus_in = 16'h1111; cycle();
        idle(); rin[1] = 1'b1; rout[1] = 1'b1; bus_in = 16'h2222; #1; check("rw_old", bus_out, 16'h1111); cycle();

        // Reset in the middle of a push sequence
        for (int k = 0; k < 3; k++) begin
            idle(); rin[15] = 1'b1; sp_sel = 2'b01; cycle();
        end
        idle(); rst = 1'b0; rin[15] = 1'b1; sp_sel = 2'b01; cycle();
        check("rst_mid_sp", sp_out, 16'hFFFF);
        idle(); rout[1] = 1'b1; #1; check("rst_mid_r1", bus_out, 16'h0000); cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 39) != 0);
            case ($urandom_range(0, 3))
                0: rin = 16'h0000;
                1: rin = 16'h0001 << $urandom_range(0, 15);
                2: rin = 16'h8000;
                default: rin = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: rout = 16'h0000;
                1, 2: rout = 16'h0001 << $urandom_range(0, 15);
                default: rout = 16'($urandom) & 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: pick = 16'hFF00 + 16'($urandom_range(0, 3));
                1: pick = 16'hFFFF - 16'($urandom_range(0, 3));
                2: pick = 16'hFEFF;
                default: pick = 16'($urandom);
            endcase
            bus_in     = pick;
            sp_sel     = 2'($urandom_range(0, 3));
            sr_sel     = 1'($urandom_range(0, 1));
            alu_status = 4'($urandom_range(0, 15));
            err_clr    = ($urandom_range(0, 7) == 0);
            dbg_sel    = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
